controle_turnos_param: RTL and testbench
========================================

// Module: controle_turnos_param
// PURPOSE
//  Parametrised turn controller for the battleship game, N players. Sequences aim X -> aim Y ->
//  fire -> result -> life check -> next turn. Shot goes to the Colisor over a valid/ready
//  handshake; hit result comes back on a valid strobe. Eliminated players are skipped.
//  Drives coordinates, attacker/target ids, winner flag and the status LEDs.
//  Sits between the input debouncers, the random generator, the Colisor and the board LEDs.
// PARAMETERS
//  COORD_W     4   coordinate width
//  BOARD_SIZE  9   legal coordinates 1..BOARD_SIZE (BOARD_SIZE < 2**COORD_W)
//  NUM_PLAYERS 2   players, 2..4
//  LIFE_W      4   width of each player's remaining-ship count
//  BLINK_BIT   23  blink-counter bit driving flashing LEDs
// PORTS
//  clk          in   1                   system clock
//  reset        in   1                   synchronous, active-high
//  enable       in   1                   0: all registers hold (reset still wins)
//  enter        in   1                   one-cycle pulse per press (already debounced)
//  select       in   1                   one-cycle pulse per press
//  mode         in   1                   1 PvP manual increment; 0 PvC random load
//  posicao_rnd  in   COORD_W             random coordinate
//  qtd_vidas    in   NUM_PLAYERS*LIFE_W  ships left, player p at [p*LIFE_W +: LIFE_W]
//  shot_valid   out  1                   shot offered to Colisor
//  shot_ready   in   1                   Colisor accepts shot
//  hit_valid    in   1                   one-cycle result strobe
//  hit          in   1                   result, qualified by hit_valid
//  coord_tiroX  out  COORD_W             shot X
//  coord_tiroY  out  COORD_W             shot Y
//  atacante     out  PW=max(1,clog2(N))  current attacker
//  alvo         out  PW                  current target
//  acertou      out  1                   latched result of last shot
//  vencedor     out  1                   game over; winner = atacante
//  LEDR, LEDG   out  8 each              status LEDs
// BEHAVIOUR
//  Reset: state AIM_X, atacante=0, alvo=next alive after 0, coords=1/1, shot_valid=0,
//    acertou=0, vencedor=0, LEDR=0, LEDG=8'h01, blink counter=0.
//  States:
//    AIM_X:  enter -> AIM_Y.
//    AIM_Y:  enter -> FIRE.
//    FIRE:   shot_valid=1. Advance on shot_valid&shot_ready -> WAIT_HIT.
//            Coordinates frozen while shot_valid is high.
//    WAIT_HIT: hit_valid -> acertou<=hit, go to SHOW.
//            hit_valid ignored in every other state.
//    SHOW:   enter -> CHECK if acertou, else NEXT.
//    CHECK:  one cycle, samples qtd_vidas.
//            alive count (nonzero lives) <= 1 -> WINNER; else NEXT.
//    NEXT:   one cycle. atacante <= next alive index after atacante (mod N).
//            alvo <= next alive after the new atacante. Coords <= 1/1. Go to AIM_X.
//    WINNER: terminal until reset. vencedor=1, atacante holds.
//  Coordinates:
//    AIM_X/AIM_Y, select pulse on the active axis.
//    mode=1: +1, BOARD_SIZE wraps to 1.
//    mode=0: load posicao_rnd if in 1..BOARD_SIZE, else hold.
//    select in other states ignored.
//    enter and select in the same cycle: select applied, then state advances.
//  Latency: enter in AIM_Y -> shot_valid=1 on the next cycle. Each transition takes 1 cycle.
//  LEDs are registered from the state, with 1-cycle lag:
//    AIM_X:  LEDG=01, LEDR=0.
//    AIM_Y:  LEDG=03, LEDR=0.
//    FIRE/WAIT_HIT: LEDR[3:0]=LEDG[3:0]=blink, upper bits 0.
//    SHOW:   hit -> LEDG all blink, LEDR=0; miss -> LEDR all blink, LEDG=0.
//    WINNER: LEDG all blink.
//    blink = counter[BLINK_BIT]. Counter wraps freely and clears on every state change.
//  enable=0 mid-handshake: shot_valid and coords hold. Colisor may still accept the shot,
//    but the transfer is not recorded until enable returns.
//  reset mid-game, including during FIRE: full reset values next cycle, shot_valid drops at once.
// TESTING
//  1) N=2, mode=1, 3 X selects, enter, 2 Y selects, enter -> coords 4/3, shot_valid next cycle.
//  2) shot_ready low 5 cycles, then high -> shot_valid high for all 6 cycles, coords stable,
//     WAIT_HIT after.
//  3) hit_valid&hit=0, enter -> atacante 0->1, alvo=0, coords 1/1, LEDG=01.
//  4) hit=1 with qtd_vidas of P1=0 -> CHECK, WINNER, vencedor=1, atacante=0, LEDG blinking.
//  5) N=3, P1 lives 0, turn passes from P0 -> atacante=2, alvo=0.
//  6) mode=0: posicao_rnd 7 then 12 -> X=7 held; X=9, mode=1 select -> X=1.
//     reset during FIRE -> AIM_X, shot_valid=0.

Source files
------------

// File: rtl/controle_turnos_param.sv
// -----------------------------------------------------------------------------
// controle_turnos_param
// Turn controller for an N-player battleship game.
// Each turn runs through these steps: aim X, aim Y, fire, wait for the result,
// show it, check lives, then pass the turn. Players with no ships left are
// skipped when the turn passes.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   enable              0 freezes every register (reset still wins)
//   enter, select       debounced one-cycle button pulses
//   mode                1 = manual +1 per select, 0 = load posicao_rnd
//   posicao_rnd         random coordinate candidate
//   qtd_vidas           ships left per player, player p at [p*LIFE_W +: LIFE_W]
//   shot_valid/ready    shot handshake towards the Colisor
//   hit_valid, hit      result strobe from the Colisor
//   coord_tiroX/Y       coordinates of the shot being aimed or fired
//   atacante, alvo      current attacker and target indices
//   acertou             latched result of the last shot
//   vencedor            game over; the winner is atacante
//   LEDR, LEDG          status LEDs, registered from the state
// -----------------------------------------------------------------------------
module controle_turnos_param #(
   parameter int COORD_W     = 4,
   parameter int BOARD_SIZE  = 9,
   parameter int NUM_PLAYERS = 2,
   parameter int LIFE_W      = 4,
   parameter int BLINK_BIT   = 23,
   localparam int PW         = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          enter,
   input  logic                          select,
   input  logic                          mode,
   input  logic [COORD_W-1:0]            posicao_rnd,
   input  logic [NUM_PLAYERS*LIFE_W-1:0] qtd_vidas,
   output logic                          shot_valid,
   input  logic                          shot_ready,
   input  logic                          hit_valid,
   input  logic                          hit,
   output logic [COORD_W-1:0]            coord_tiroX,
   output logic [COORD_W-1:0]            coord_tiroY,
   output logic [PW-1:0]                 atacante,
   output logic [PW-1:0]                 alvo,
   output logic                          acertou,
   output logic                          vencedor,
   output logic [7:0]                    LEDR,
   output logic [7:0]                    LEDG
);

   typedef enum logic [2:0] {
      AIM_X, AIM_Y, FIRE, WAIT_HIT, SHOW, CHECK, NEXT, WINNER
   } state_t;

   state_t               state_q, state_d;
   logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
   logic [PW-1:0]        att_q, att_d, alvo_q, alvo_d;
   logic                 acertou_q, acertou_d;
   logic [BLINK_BIT:0]   cnt_q, cnt_d;
   logic [7:0]           ledr_q, ledr_d, ledg_q, ledg_d;
   logic [NUM_PLAYERS-1:0] alive;
   logic                 blink;

   // One flag per player: still has at least one ship.
   generate
      for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_alive
         assign alive[gi] = |qtd_vidas[gi*LIFE_W +: LIFE_W];
      end
   endgenerate

   // First alive player strictly after cur, wrapping modulo N. If nobody else
   // is alive, cur is returned. The loop runs downward so the closest hit wins.
   function automatic logic [PW-1:0] next_alive(input logic [PW-1:0] cur,
                                                input logic [NUM_PLAYERS-1:0] alv);
      logic [PW-1:0] res;
      int            idx;
      res = cur;
      for (int k = NUM_PLAYERS - 1; k >= 1; k--) begin
         idx = (int'(cur) + k) % NUM_PLAYERS;
         if (alv[idx]) res = PW'(idx);
      end
      return res;
   endfunction

   // Coordinate update on a select pulse.
   function automatic logic [COORD_W-1:0] step_coord(input logic [COORD_W-1:0] c,
                                                     input logic m,
                                                     input logic [COORD_W-1:0] rnd);
      if (m)
         return (c == COORD_W'(BOARD_SIZE)) ? COORD_W'(1) : c + COORD_W'(1);
      else if (rnd != '0 && rnd <= COORD_W'(BOARD_SIZE))
         return rnd;
      else
         return c;
   endfunction

   assign blink = cnt_q[BLINK_BIT];

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      att_d     = att_q;
      alvo_d    = alvo_q;
      acertou_d = acertou_q;
      cnt_d     = cnt_q + 1'b1;
      ledr_d    = 8'h00;
      ledg_d    = 8'h00;

      case (state_q)
         AIM_X: begin
            if (select) x_d = step_coord(x_q, mode, posicao_rnd);
            if (enter)  state_d = AIM_Y;
         end
         AIM_Y: begin
            if (select) y_d = step_coord(y_q, mode, posicao_rnd);
            if (enter)  state_d = FIRE;
         end
         FIRE: begin
            if (shot_ready) state_d = WAIT_HIT;
         end
         WAIT_HIT: begin
            if (hit_valid) begin
               acertou_d = hit;
               state_d   = SHOW;
            end
         end
         SHOW: begin
            if (enter) state_d = acertou_q ? CHECK : NEXT;
         end
         CHECK: begin
            state_d = ($countones(alive) <= 1) ? WINNER : NEXT;
         end
         NEXT: begin
            att_d   = next_alive(att_q, alive);
            alvo_d  = next_alive(att_d, alive);
            x_d     = COORD_W'(1);
            y_d     = COORD_W'(1);
            state_d = AIM_X;
         end
         WINNER: begin
            state_d = WINNER;
         end
         default: state_d = AIM_X;
      endcase

      // The blink phase restarts with every state change.
      if (state_d != state_q) cnt_d = '0;

      // LEDs follow the current state and show up one cycle later.
      case (state_q)
         AIM_X:          ledg_d = 8'h01;
         AIM_Y:          ledg_d = 8'h03;
         FIRE, WAIT_HIT: begin
            ledg_d = {4'h0, {4{blink}}};
            ledr_d = {4'h0, {4{blink}}};
         end
         SHOW: begin
            if (acertou_q) ledg_d = {8{blink}};
            else           ledr_d = {8{blink}};
         end
         WINNER:         ledg_d = {8{blink}};
         default: begin
            ledg_d = 8'h00;
            ledr_d = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= AIM_X;
      end else if (enable) begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q       <= COORD_W'(1);
         y_q       <= COORD_W'(1);
         att_q     <= '0;
         alvo_q    <= next_alive('0, alive);
         acertou_q <= 1'b0;
         cnt_q     <= '0;
         ledr_q    <= 8'h00;
         ledg_q    <= 8'h01;
      end else if (enable) begin
         x_q       <= x_d;
         y_q       <= y_d;
         att_q     <= att_d;
         alvo_q    <= alvo_d;
         acertou_q <= acertou_d;
         cnt_q     <= cnt_d;
         ledr_q    <= ledr_d;
         ledg_q    <= ledg_d;
      end
   end

   // The reset term drops an outstanding shot in the same cycle reset rises.
   assign shot_valid  = (state_q == FIRE) && !reset;
   assign vencedor    = (state_q == WINNER);
   assign coord_tiroX = x_q;
   assign coord_tiroY = y_q;
   assign atacante    = att_q;
   assign alvo        = alvo_q;
   assign acertou     = acertou_q;
   assign LEDR        = ledr_q;
   assign LEDG        = ledg_q;

endmodule

// File: tb/tb_controle_turnos_param.sv
module tb_controle_turnos_param;
   logic clk = 1'b0;
   logic reset, enable, enter, select, mode, shot_ready, hit_valid, hit;
   logic [3:0]  rnd;
   logic [7:0]  qtd2;
   logic [11:0] qtd3;

   logic       sv2, acertou2, venc2;
   logic [3:0] x2, y2;
   logic [0:0] att2, alvo2;
   logic [7:0] ledr2, ledg2;

   logic       sv3, acertou3, venc3;
   logic [3:0] x3, y3;
   logic [1:0] att3, alvo3;
   logic [7:0] ledr3, ledg3;

   int errors = 0;
   int checks = 0;
   logic saw00, sawff;

   always #5 clk = ~clk;

   controle_turnos_param #(.NUM_PLAYERS(2), .BLINK_BIT(2)) dut2 (
      .clk(clk), .reset(reset), .enable(enable), .enter(enter), .select(select),
      .mode(mode), .posicao_rnd(rnd), .qtd_vidas(qtd2), .shot_valid(sv2),
      .shot_ready(shot_ready), .hit_valid(hit_valid), .hit(hit),
      .coord_tiroX(x2), .coord_tiroY(y2), .atacante(att2), .alvo(alvo2),
      .acertou(acertou2), .vencedor(venc2), .LEDR(ledr2), .LEDG(ledg2));

   controle_turnos_param #(.NUM_PLAYERS(3), .BLINK_BIT(2)) dut3 (
      .clk(clk), .reset(reset), .enable(enable), .enter(enter), .select(select),
      .mode(mode), .posicao_rnd(rnd), .qtd_vidas(qtd3), .shot_valid(sv3),
      .shot_ready(shot_ready), .hit_valid(hit_valid), .hit(hit),
      .coord_tiroX(x3), .coord_tiroY(y3), .atacante(att3), .alvo(alvo3),
      .acertou(acertou3), .vencedor(venc3), .LEDR(ledr3), .LEDG(ledg3));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic press_enter;
      enter = 1'b1; tick; enter = 1'b0;
   endtask

   task automatic press_select;
      select = 1'b1; tick; select = 1'b0;
   endtask

   // Full turn from AIM_X: aim, fire, result, acknowledge, one more cycle.
   task automatic play_turn(input logic hv);
      press_enter;
      press_enter;
      shot_ready = 1'b1; tick; shot_ready = 1'b0;
      hit_valid = 1'b1; hit = hv; tick; hit_valid = 1'b0; hit = 1'b0;
      press_enter;
      tick;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; enter = 1'b0; select = 1'b0; mode = 1'b1;
      shot_ready = 1'b0; hit_valid = 1'b0; hit = 1'b0; rnd = 4'd0;
      qtd2 = 8'h33;        // P0=3, P1=3
      qtd3 = 12'h303;      // P0=3, P1=0, P2=3
      tick; tick;
      reset = 1'b0;

      // reset state
      check("rst_x", x2, 1);
      check("rst_y", y2, 1);
      check("rst_att", att2, 0);
      check("rst_alvo", alvo2, 1);
      check("rst_alvo3", alvo3, 2);
      check("rst_sv", sv2, 0);
      check("rst_acertou", acertou2, 0);
      check("rst_venc", venc2, 0);
      check("rst_ledg", ledg2, 8'h01);
      check("rst_ledr", ledr2, 8'h00);

      // 3 X selects in manual mode
      select = 1'b1; tick; tick; tick; select = 1'b0;
      check("x_after_3sel", x2, 4);
      check("y_untouched", y2, 1);
      press_enter;
      check("ledg_lag", ledg2, 8'h01);
      tick;
      check("ledg_aim_y", ledg2, 8'h03);
      press_select;
      // select together with enter: select applied, then FIRE
      select = 1'b1; enter = 1'b1; tick; select = 1'b0; enter = 1'b0;
      check("sv_next_cycle", sv2, 1);
      check("fire_x", x2, 4);
      check("fire_y", y2, 3);

      // shot_ready held low: valid and coords stay put, select ignored
      for (int i = 0; i < 4; i++) begin
         select = 1'b1; tick; select = 1'b0;
         check("sv_wait", sv2, 1);
         check("x_frozen", x2, 4);
      end
      check("ledg_fire_upper", ledg2[7:4], 0);
      // Colisor ready while disabled: transfer not recorded
      enable = 1'b0; shot_ready = 1'b1; tick;
      check("sv_disabled", sv2, 1);
      enable = 1'b1; tick; shot_ready = 1'b0;
      check("sv_accepted", sv2, 0);
      check("y_after_fire", y2, 3);

      // miss result
      hit_valid = 1'b1; hit = 1'b0; tick; hit_valid = 1'b0;
      check("acertou_miss", acertou2, 0);
      press_enter;
      tick;
      check("t1_att", att2, 1);
      check("t1_alvo", alvo2, 0);
      check("t1_x", x2, 1);
      check("t1_y", y2, 1);
      check("t1_att3", att3, 2);
      check("t1_alvo3", alvo3, 0);
      tick;
      check("t1_ledg", ledg2, 8'h01);
      check("t1_ledr", ledr2, 8'h00);

      // hit_valid outside WAIT_HIT has no effect
      hit_valid = 1'b1; hit = 1'b1; tick; hit_valid = 1'b0; hit = 1'b0;
      check("hit_ignored", acertou2, 0);
      check("still_aim", sv2, 0);

      // second turn (miss): turn wraps back to P0
      play_turn(1'b0);
      check("t2_att", att2, 0);
      check("t2_alvo", alvo2, 1);
      check("t2_att3", att3, 0);
      check("t2_alvo3", alvo3, 2);

      // third turn: hit, P1 out of ships -> winner P0
      qtd2 = 8'h03;
      press_enter;
      press_enter;
      shot_ready = 1'b1; tick; shot_ready = 1'b0;
      hit_valid = 1'b1; hit = 1'b1; tick; hit_valid = 1'b0; hit = 1'b0;
      check("acertou_hit", acertou2, 1);
      press_enter;
      check("venc_in_check", venc2, 0);
      tick;
      check("venc", venc2, 1);
      check("winner_att", att2, 0);
      saw00 = 1'b0; sawff = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (ledg2 == 8'h00) saw00 = 1'b1;
         if (ledg2 == 8'hff) sawff = 1'b1;
      end
      check("winner_blink_off", saw00, 1);
      check("winner_blink_on", sawff, 1);
      check("winner_ledr", ledr2, 8'h00);
      // three-player game still has two alive players and continues
      check("t3_venc3", venc3, 0);
      check("t3_att3", att3, 2);
      check("t3_alvo3", alvo3, 0);
      check("t3_sv3", sv3, 0);
      press_enter;
      check("winner_terminal", venc2, 1);
      check("winner_att_hold", att2, 0);

      // random-load mode
      qtd2 = 8'h33;
      reset = 1'b1; tick; reset = 1'b0;
      check("rst2_venc", venc2, 0);
      check("rst2_alvo", alvo2, 1);
      mode = 1'b0;
      rnd = 4'd7;  press_select; check("rnd7", x2, 7);
      rnd = 4'd12; press_select; check("rnd12_hold", x2, 7);
      rnd = 4'd0;  press_select; check("rnd0_hold", x2, 7);
      rnd = 4'd9;  press_select; check("rnd9", x2, 9);
      mode = 1'b1; press_select; check("wrap", x2, 1);
      enable = 1'b0; press_select; enable = 1'b1;
      check("disabled_sel", x2, 1);
      press_enter;
      mode = 1'b0; rnd = 4'd5; press_select;
      check("rnd_y", y2, 5);
      check("x_kept", x2, 1);
      press_enter;
      check("fire2_sv", sv2, 1);

      // reset during FIRE
      reset = 1'b1; #1;
      check("sv_drop_now", sv2, 0);
      tick;
      check("rst3_x", x2, 1);
      check("rst3_y", y2, 1);
      check("rst3_ledg", ledg2, 8'h01);
      reset = 1'b0; tick;
      check("rst3_sv", sv2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
